// File: rtl/aa_pkg.sv
// Shared types for the anti-aliasing neighbourhood path: default geometry,
// window-generator states, the window payload and line-buffer rotation helpers.
package aa_pkg;

    localparam int unsigned AA_PIX_W = 10;
    localparam int unsigned AA_IMG_W = 64;
    localparam int unsigned AA_IMG_H = 64;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH,
        DONE
    } aa_win_state_t;

    typedef struct packed {
        logic [AA_PIX_W-1:0] c;
        logic [AA_PIX_W-1:0] n;
        logic [AA_PIX_W-1:0] s;
        logic [AA_PIX_W-1:0] e;
        logic [AA_PIX_W-1:0] w;
        logic                border;
    } aa_window_t;

    // Line-buffer rotation over three buffers, wrapping 2 -> 0.
    function automatic logic [1:0] lb_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] lb_prev(input logic [1:0] p);
        return (p == 2'd0) ? 2'd2 : p - 2'd1;
    endfunction

endpackage

// File: rtl/aa_line_buf.sv
// One row of pixels: single write port, combinational reads of a column and
// its west/east neighbours (neighbour addresses clamp at the row ends).
module aa_line_buf
    import aa_pkg::*;
#(
    parameter int unsigned PIX_W = AA_PIX_W,
    parameter int unsigned IMG_W = AA_IMG_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(IMG_W)-1:0] waddr,
    input  logic [PIX_W-1:0]         wdata,
    input  logic [$clog2(IMG_W)-1:0] raddr,
    output logic [PIX_W-1:0]         ctr_c,
    output logic [PIX_W-1:0]         west_c,
    output logic [PIX_W-1:0]         east_c
);

    localparam int unsigned AW = $clog2(IMG_W);
    localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_W - 1);

    logic [PIX_W-1:0] mem [IMG_W];
    logic [AW-1:0]    addr_w;
    logic [AW-1:0]    addr_e;

    // Pixel storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        addr_w = (raddr == '0)        ? raddr : raddr - 1'b1;
        addr_e = (raddr == ADDR_LAST) ? raddr : raddr + 1'b1;
        ctr_c  = mem[raddr];
        west_c = mem[addr_w];
        east_c = mem[addr_e];
    end

endmodule

// File: rtl/aa_window_gen.sv
// Raster-stream to 5-point cross window generator feeding the AA stage.
// Define AA_WIN_ZERO_PAD_EN to drive missing edge neighbours to 0 instead of C.
module aa_window_gen
    import aa_pkg::*;
#(
    parameter int unsigned PIX_W = AA_PIX_W,
    parameter int unsigned IMG_W = AA_IMG_W,
    parameter int unsigned IMG_H = AA_IMG_H
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         out_c,
    output logic [PIX_W-1:0]         out_n,
    output logic [PIX_W-1:0]         out_s,
    output logic [PIX_W-1:0]         out_e,
    output logic [PIX_W-1:0]         out_w,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     out_border,
    output logic                     frame_done
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    aa_win_state_t state, state_nxt;

    logic          alive;
    logic [RW-1:0] in_row;
    logic [CW-1:0] in_col;
    logic [1:0]    wr_ptr;
    logic          in_fire, out_fire, in_last_col, in_last_row, out_last, load_win;

    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          win_bot, win_border;
    logic [1:0]    c_ptr, n_ptr;

    logic [2:0]       lb_we;
    logic [PIX_W-1:0] lb_ctr  [3];
    logic [PIX_W-1:0] lb_west [3];
    logic [PIX_W-1:0] lb_east [3];
    logic [PIX_W-1:0] ctr_v, edge_v, nxt_n, nxt_s, nxt_e, nxt_w;

    // alive keeps in_ready low while reset is applied.
    assign in_ready = alive && ((state == IDLE) || (state == FILL) ||
                                ((state == STREAM) && (!out_valid || out_ready)));

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign in_last_col = (in_col == COL_LAST);
    assign in_last_row = (in_row == ROW_LAST);
    assign out_last    = (out_row == ROW_LAST) && (out_col == COL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_win  = 1'b0;
        case (state)
            IDLE:   if (in_fire) state_nxt = FILL;
            FILL:   if (in_fire && in_last_col) state_nxt = STREAM;
            STREAM: begin
                if (in_fire) begin
                    load_win = 1'b1;
                    if (in_last_col && in_last_row) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (out_fire) begin
                    if (out_last) state_nxt = DONE;
                    else          load_win  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input raster position and the buffer receiving the current input row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive  <= 1'b0;
            in_row <= '0;
            in_col <= '0;
            wr_ptr <= 2'd0;
        end else begin
            alive <= 1'b1;
            if (state == DONE) begin
                in_row <= '0;
                in_col <= '0;
                wr_ptr <= 2'd0;
            end else if (in_fire) begin
                if (in_last_col) begin
                    in_col <= '0;
                    in_row <= in_last_row ? '0 : in_row + 1'b1;
                    wr_ptr <= lb_next(wr_ptr);
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_lb
        assign lb_we[i] = in_fire && (wr_ptr == 2'(i));

        aa_line_buf #(
            .PIX_W (PIX_W),
            .IMG_W (IMG_W)
        ) u_lb (
            .clk    (clk),
            .we     (lb_we[i]),
            .waddr  (in_col),
            .wdata  (in_pix),
            .raddr  (win_col),
            .ctr_c  (lb_ctr[i]),
            .west_c (lb_west[i]),
            .east_c (lb_east[i])
        );
    end

    // Center row sits one buffer behind the write pointer, north row two behind;
    // this holds in FLUSH too because wr_ptr has advanced past the last row.
    always_comb begin
        win_row = in_row - 1'b1;
        win_col = in_col;
        win_bot = 1'b0;
        if (state == FLUSH) begin
            win_row = ROW_LAST;
            win_col = (out_col == COL_LAST) ? '0 : out_col + 1'b1;
            win_bot = 1'b1;
        end
        c_ptr = lb_prev(wr_ptr);
        n_ptr = lb_next(wr_ptr);
        ctr_v = lb_ctr[c_ptr];
`ifdef AA_WIN_ZERO_PAD_EN
        edge_v = '0;
`else
        edge_v = ctr_v;
`endif
        nxt_n      = (win_row == '0)       ? edge_v : lb_ctr[n_ptr];
        nxt_s      = win_bot               ? edge_v : in_pix;
        nxt_w      = (win_col == '0)       ? edge_v : lb_west[c_ptr];
        nxt_e      = (win_col == COL_LAST) ? edge_v : lb_east[c_ptr];
        win_border = (win_row == '0) || win_bot || (win_col == '0) || (win_col == COL_LAST);
    end

    // Single-entry output register; a load and an accept in one cycle leave no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_c      <= '0;
            out_n      <= '0;
            out_s      <= '0;
            out_e      <= '0;
            out_w      <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_border <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == FLUSH) && (state_nxt == DONE);
            if (load_win) begin
                out_valid  <= 1'b1;
                out_c      <= ctr_v;
                out_n      <= nxt_n;
                out_s      <= nxt_s;
                out_e      <= nxt_e;
                out_w      <= nxt_w;
                out_row    <= win_row;
                out_col    <= win_col;
                out_border <= win_border;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aa_window_gen.sv
// Directed bench for aa_window_gen on a 4x3 frame; expectations follow
// AA_WIN_ZERO_PAD_EN when it is defined for the build.
module tb_aa_window_gen;

    localparam int PW   = 10;
    localparam int IW   = 4;
    localparam int IH   = 3;
    localparam int WINB = 2 + 2 + 5 * PW + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pix;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_c, out_n, out_s, out_e, out_w;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic          out_border;
    logic          frame_done;

    always #5 clk = ~clk;

    aa_window_gen #(
        .PIX_W (PW),
        .IMG_W (IW),
        .IMG_H (IH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_n      (out_n),
        .out_s      (out_s),
        .out_e      (out_e),
        .out_w      (out_w),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_border (out_border),
        .frame_done (frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [WINB-1:0] obs [64];
    int n_obs, done_cnt, done_cyc, last_hs_cyc, hold_cnt, stab_err, inrdy_err, flush_err;
    bit drv_done, tmo;

    function automatic logic [PW-1:0] px(input int base, input int r, input int c);
        return PW'(base + 10 * r + c);
    endfunction

    // Reference window for (r,c) of a frame whose pixels are base+10r+c.
    function automatic logic [WINB-1:0] exp_win(input int base, input int r, input int c);
        logic [PW-1:0] cv, nv, sv, ev, wv, edge_v;
        logic b;
        cv = px(base, r, c);
`ifdef AA_WIN_ZERO_PAD_EN
        edge_v = '0;
`else
        edge_v = cv;
`endif
        nv = (r == 0)      ? edge_v : px(base, r - 1, c);
        sv = (r == IH - 1) ? edge_v : px(base, r + 1, c);
        wv = (c == 0)      ? edge_v : px(base, r, c - 1);
        ev = (c == IW - 1) ? edge_v : px(base, r, c + 1);
        b  = (r == 0) || (r == IH - 1) || (c == 0) || (c == IW - 1);
        return {2'(r), 2'(c), cv, nv, sv, ev, wv, b};
    endfunction

    function automatic logic [WINB-1:0] snap();
        return {out_row, out_col, out_c, out_n, out_s, out_e, out_w, out_border};
    endfunction

    task automatic push(input logic [PW-1:0] v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_pix   = v;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) tmo = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Streams n_pix pixels while recording accepted windows and handshake events.
    // mode 0: out_ready held high; mode 1: out_ready cycles 1,0,0,1.
    task automatic run_frames(input int base, input int mode, input int n_pix, input int nfr);
        bit prev_hold;
        logic [WINB-1:0] prev_snap, cur;
        int post;
        for (int i = 0; i < 64; i++) obs[i] = 'x;
        n_obs = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        hold_cnt = 0; stab_err = 0; inrdy_err = 0; flush_err = 0;
        drv_done = 1'b0; tmo = 1'b0; prev_hold = 1'b0; prev_snap = '0; post = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < n_pix; i++) push(px(base, (i / IW) % IH, i % IW));
                drv_done = 1'b1;
            end
            begin
                for (int cyc = 0; cyc < 600 && post < 3; cyc++) begin
                    @(negedge clk);
                    cur = snap();
                    if (prev_hold && (!out_valid || cur !== prev_snap)) stab_err++;
                    if (out_valid && !out_ready) begin
                        hold_cnt++;
                        if (in_ready) inrdy_err++;
                    end
                    if (drv_done && done_cnt == 0 && in_ready) flush_err++;
                    if (out_valid && out_ready) begin
                        if (n_obs < 64) obs[n_obs] = cur;
                        n_obs++;
                        last_hs_cyc = cyc;
                    end
                    if (frame_done) begin
                        done_cnt++;
                        done_cyc = cyc;
                    end
                    prev_hold = out_valid && !out_ready;
                    prev_snap = cur;
                    if (done_cnt >= nfr) post++;
                    @(posedge clk);
                    #1;
                    if (mode == 1) out_ready = (((cyc + 1) % 4) == 0) || (((cyc + 1) % 4) == 3);
                end
                if (done_cnt < nfr) tmo = 1'b1;
            end
        join
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_pix = '0; out_ready = 1'b0;
        #12;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        n_chk++; if (snap() !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", snap()); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_ramp();
        logic [WINB-1:0] e;
        logic [5*PW:0] hand;
        run_frames(0, 0, IW * IH, 1);
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ramp_timeout: got %b expected 0", tmo); end
        n_chk++; if (n_obs != 12) begin n_fail++; $display("FAIL ramp_count: got %0d expected 12", n_obs); end
        for (int i = 0; i < 12; i++) begin
            e = exp_win(0, i / IW, i % IW);
            n_chk++; if (obs[i] !== e) begin n_fail++; $display("FAIL ramp_win%0d: got %h expected %h", i, obs[i], e); end
        end
        // fields {c,n,s,e,w,border}
        hand = {10'd11, 10'd1, 10'd21, 10'd12, 10'd10, 1'b0};
        n_chk++; if (obs[5][5*PW:0] !== hand) begin n_fail++; $display("FAIL ramp_w11: got %h expected %h", obs[5][5*PW:0], hand); end
        hand = {10'd0, 10'd0, 10'd10, 10'd1, 10'd0, 1'b1};
        n_chk++; if (obs[0][5*PW:0] !== hand) begin n_fail++; $display("FAIL ramp_w00: got %h expected %h", obs[0][5*PW:0], hand); end
`ifdef AA_WIN_ZERO_PAD_EN
        hand = {10'd23, 10'd13, 10'd0, 10'd0, 10'd22, 1'b1};
`else
        hand = {10'd23, 10'd13, 10'd23, 10'd23, 10'd22, 1'b1};
`endif
        n_chk++; if (obs[11][5*PW:0] !== hand) begin n_fail++; $display("FAIL ramp_w23: got %h expected %h", obs[11][5*PW:0], hand); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL ramp_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_stall();
        logic [WINB-1:0] e;
        run_frames(0, 1, IW * IH, 1);
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %b expected 0", tmo); end
        n_chk++; if (n_obs != 12) begin n_fail++; $display("FAIL stall_count: got %0d expected 12", n_obs); end
        for (int i = 0; i < 12; i++) begin
            e = exp_win(0, i / IW, i % IW);
            n_chk++; if (obs[i] !== e) begin n_fail++; $display("FAIL stall_win%0d: got %h expected %h", i, obs[i], e); end
        end
        n_chk++; if (hold_cnt == 0) begin n_fail++; $display("FAIL stall_held_cycles: got %0d expected >0", hold_cnt); end
        n_chk++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", stab_err); end
        n_chk++; if (inrdy_err != 0) begin n_fail++; $display("FAIL stall_in_ready: got %0d ready-while-held expected 0", inrdy_err); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_flush();
        int row2;
        run_frames(0, 0, IW * IH, 1);
        row2 = 0;
        for (int i = 0; i < 12; i++) if (obs[i][WINB-1 -: 2] == 2'd2) row2++;
        n_chk++; if (flush_err != 0) begin n_fail++; $display("FAIL flush_in_ready: got %0d ready cycles expected 0", flush_err); end
        n_chk++; if (row2 != 4) begin n_fail++; $display("FAIL flush_row2_count: got %0d expected 4", row2); end
        n_chk++; if (obs[11][WINB-1 -: 4] !== 4'b10_11) begin n_fail++; $display("FAIL flush_last_pos: got %b expected 1011", obs[11][WINB-1 -: 4]); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL flush_done_cnt: got %0d expected 1", done_cnt); end
        n_chk++; if (done_cyc != last_hs_cyc + 1) begin n_fail++; $display("FAIL flush_done_timing: got cycle %0d expected %0d", done_cyc, last_hs_cyc + 1); end
    endtask

    task automatic test_reset_mid();
        bit fd_seen;
        logic [WINB-1:0] e;
        fd_seen   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(px(0, i / IW, i % IW));
            if (frame_done) fd_seen = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done) fd_seen = 1'b1;
        end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
        reset_n = 1'b1;
        run_frames(100, 0, IW * IH, 1);
        n_chk++; if (fd_seen !== 1'b0) begin n_fail++; $display("FAIL mid_abort_done: got %b expected 0", fd_seen); end
        n_chk++; if (n_obs != 12) begin n_fail++; $display("FAIL mid_count: got %0d expected 12", n_obs); end
        n_chk++; if (obs[0][WINB-1 -: 4+PW] !== {4'b0000, 10'd100}) begin n_fail++; $display("FAIL mid_first_c: got %h expected %h", obs[0][WINB-1 -: 4+PW], {4'b0000, 10'd100}); end
        e = exp_win(100, 0, 0);
        n_chk++; if (obs[0] !== e) begin n_fail++; $display("FAIL mid_win0: got %h expected %h", obs[0], e); end
        e = exp_win(100, 2, 3);
        n_chk++; if (obs[11] !== e) begin n_fail++; $display("FAIL mid_win11: got %h expected %h", obs[11], e); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL mid_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [WINB-1:0] e;
        run_frames(0, 0, 2 * IW * IH, 2);
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b expected 0", tmo); end
        n_chk++; if (n_obs != 24) begin n_fail++; $display("FAIL b2b_count: got %0d expected 24", n_obs); end
        n_chk++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d expected 2", done_cnt); end
        for (int i = 0; i < 24; i++) begin
            e = exp_win(0, (i / IW) % IH, i % IW);
            n_chk++; if (obs[i] !== e) begin n_fail++; $display("FAIL b2b_win%0d: got %h expected %h", i, obs[i], e); end
        end
        n_chk++; if (obs[17][WINB-1 -: 4+PW] !== {4'b0101, 10'd11}) begin n_fail++; $display("FAIL b2b_f2_w11: got %h expected %h", obs[17][WINB-1 -: 4+PW], {4'b0101, 10'd11}); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
